// File: rtl/skyline_area.sv
// Skyline area reducer: consumes one image's alternating x,h key-point burst and
// emits one registered result beat (area, peak height, pair count, format errors).
module skyline_area #(
  parameter int DATA_WIDTH = 6,
  parameter int AREA_WIDTH = 12,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  AREA_VALID,
  output logic [AREA_WIDTH-1:0] AREA,
  output logic [DATA_WIDTH-1:0] MAX_H,
  output logic [CNT_WIDTH-2:0]  PT_CNT,
  output logic [2:0]            ERR,
  output logic                  DROP
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [AREA_WIDTH-1:0] acc_q, acc_d;
  logic [AREA_WIDTH-1:0] prod_q, prod_d;
  logic                  prod_v_q, prod_v_d;
  logic [DATA_WIDTH-1:0] x_cur_q, x_cur_d;
  logic [DATA_WIDTH-1:0] x_prev_q, x_prev_d;
  logic [DATA_WIDTH-1:0] h_prev_q, h_prev_d;
  logic                  have_prev_q, have_prev_d;
  logic                  parity_q, parity_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] max_h_q, max_h_d;
  logic                  err_ord_q, err_ord_d;
  logic [AREA_WIDTH-1:0] area_o_q, area_o_d;
  logic [DATA_WIDTH-1:0] max_h_o_q, max_h_o_d;
  logic [CNT_WIDTH-2:0]  pt_cnt_o_q, pt_cnt_o_d;
  logic [2:0]            err_o_q, err_o_d;
  logic                  area_valid_q, area_valid_d;
  logic                  drop_q, drop_d;

  logic                  take_word;
  logic                  odd_words;
  logic [DATA_WIDTH-1:0] dx;
  logic [AREA_WIDTH-1:0] prod_w;

  assign take_word = IN_VALID && ((state_q == S_IDLE) || (state_q == S_RECV));
  assign dx        = IN_DATA - x_prev_q;
  assign prod_w    = AREA_WIDTH'(dx) * AREA_WIDTH'(h_prev_q);
  // Once the counter saturates its LSB no longer tracks parity; fall back to the toggle.
  assign odd_words = (word_cnt_q == CNT_MAX) ? parity_q : word_cnt_q[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (IN_VALID) state_d = S_RECV;
      S_RECV:  if (!IN_VALID) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    acc_d        = acc_q;
    prod_d       = prod_q;
    prod_v_d     = 1'b0;
    x_cur_d      = x_cur_q;
    x_prev_d     = x_prev_q;
    h_prev_d     = h_prev_q;
    have_prev_d  = have_prev_q;
    parity_d     = parity_q;
    word_cnt_d   = word_cnt_q;
    max_h_d      = max_h_q;
    err_ord_d    = err_ord_q;
    area_o_d     = area_o_q;
    max_h_o_d    = max_h_o_q;
    pt_cnt_o_d   = pt_cnt_o_q;
    err_o_d      = err_o_q;
    area_valid_d = 1'b0;
    drop_d       = drop_q;

    if (prod_v_q) acc_d = acc_q + prod_q;

    if (take_word) begin
      parity_d = ~parity_q;
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
      if (!parity_q) begin
        x_cur_d = IN_DATA;
        if (have_prev_q) begin
          if (IN_DATA > x_prev_q) begin
            prod_d   = prod_w;
            prod_v_d = 1'b1;
          end else begin
            prod_d    = '0;
            err_ord_d = 1'b1;
          end
        end
      end else begin
        x_prev_d    = x_cur_q;
        h_prev_d    = IN_DATA;
        have_prev_d = 1'b1;
        if (IN_DATA > max_h_q) max_h_d = IN_DATA;
      end
    end

    if (IN_VALID && ((state_q == S_FLUSH) || (state_q == S_DONE))) drop_d = 1'b1;

    if (state_q == S_FLUSH) begin
      area_o_d     = acc_d;
      max_h_o_d    = max_h_q;
      pt_cnt_o_d   = word_cnt_q[CNT_WIDTH-1:1];
      err_o_d      = {(!have_prev_q || (h_prev_q != '0)), err_ord_q, odd_words};
      area_valid_d = 1'b1;
    end

    if (state_q == S_DONE) begin
      acc_d       = '0;
      prod_d      = '0;
      prod_v_d    = 1'b0;
      x_cur_d     = '0;
      x_prev_d    = '0;
      h_prev_d    = '0;
      have_prev_d = 1'b0;
      parity_d    = 1'b0;
      word_cnt_d  = '0;
      max_h_d     = '0;
      err_ord_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      x_cur_q      <= '0;
      x_prev_q     <= '0;
      h_prev_q     <= '0;
      have_prev_q  <= 1'b0;
      parity_q     <= 1'b0;
      word_cnt_q   <= '0;
      max_h_q      <= '0;
      err_ord_q    <= 1'b0;
      area_o_q     <= '0;
      max_h_o_q    <= '0;
      pt_cnt_o_q   <= '0;
      err_o_q      <= '0;
      area_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      prod_v_q     <= prod_v_d;
      x_cur_q      <= x_cur_d;
      x_prev_q     <= x_prev_d;
      h_prev_q     <= h_prev_d;
      have_prev_q  <= have_prev_d;
      parity_q     <= parity_d;
      word_cnt_q   <= word_cnt_d;
      max_h_q      <= max_h_d;
      err_ord_q    <= err_ord_d;
      area_o_q     <= area_o_d;
      max_h_o_q    <= max_h_o_d;
      pt_cnt_o_q   <= pt_cnt_o_d;
      err_o_q      <= err_o_d;
      area_valid_q <= area_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign AREA_VALID = area_valid_q;
  assign AREA       = area_o_q;
  assign MAX_H      = max_h_o_q;
  assign PT_CNT     = pt_cnt_o_q;
  assign ERR        = err_o_q;
  assign DROP       = drop_q;

endmodule
